// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches the word at PCValue from variable-latency instruction memory into the IF/ID register.
// Define IFU_STALL_COUNT_EN to build the saturating stop-cycle counter on stall_cycles.
module instr_fetch_unit #(
    parameter int N = 32,
    parameter int MEM_ADDR_W = 10,
    parameter logic [31:0] TEXT_BASE = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          PCValue,
    input  logic                  flush,
    input  logic                  id_stall,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           Instruction,
    output logic [N-1:0]          InstrPC,
    output logic                  InstrValid,
    output logic                  stop,
    output logic                  addr_fault,
    output logic [31:0]           stall_cycles
);
    typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;
    localparam logic [N-1:0] BASE = N'(TEXT_BASE);
    state_t state;
    logic [N-1:0] req_pc, offset;
    logic legal, issue, capture;
    assign offset = PCValue - BASE;
    assign legal = PCValue[1:0] == 2'b00 && PCValue >= BASE && offset < (N'(1) << (MEM_ADDR_W + 2));
    // Issuing while the register is draining is safe: it empties on the same edge.
    assign issue = state == IDLE && legal && !addr_fault && !flush && !(InstrValid && id_stall);
    assign capture = state == REQ && mem_ready && !flush;
    assign stop = reset || !(flush || (state == REQ && mem_ready));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            req_pc      <= BASE;
            Instruction <= '0;
            InstrPC     <= BASE;
            InstrValid  <= 1'b0;
            addr_fault  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        mem_req  <= 1'b1;
                        mem_addr <= offset[MEM_ADDR_W+1:2];
                        req_pc   <= PCValue;
                        state    <= REQ;
                    end else if (!legal) begin
                        addr_fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        state <= KILL;
                    end
                end
                KILL: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (capture) begin
                Instruction <= mem_rdata;
                InstrPC     <= req_pc;
                InstrValid  <= 1'b1;
            end else if (flush) begin
                Instruction <= '0;
                InstrValid  <= 1'b0;
            end else if (!id_stall) begin
                InstrValid <= 1'b0;
            end
        end
    end
`ifdef IFU_STALL_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (stop && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table of fetch transactions plus hand-written stall, flush, fault and reset sequences.
module tb_instr_fetch_unit;
    localparam logic [31:0] BASE = 32'h0040_0000;
    logic clk = 1'b0;
    logic reset, flush, id_stall, mem_ready;
    logic [31:0] PCValue, mem_rdata;
    logic mem_req, InstrValid, stop, addr_fault;
    logic [9:0] mem_addr;
    logic [31:0] Instruction, InstrPC, stall_cycles;
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic [31:0] pc;
        int          lat;
        logic [31:0] data;
        logic [9:0]  addr;
    } vec_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    vec_t vecs[5];
    exp_t sb[$];
    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .PCValue(PCValue), .flush(flush), .id_stall(id_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .Instruction(Instruction), .InstrPC(InstrPC), .InstrValid(InstrValid), .stop(stop),
        .addr_fault(addr_fault), .stall_cycles(stall_cycles)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // Drives the ready pulse in a REQ cycle and checks the captured word one edge later.
    task automatic complete(input logic [31:0] data, input logic [31:0] pc);
        exp_t e;
        mem_ready = 1'b1;
        mem_rdata = data;
        #1;
        chk("stop_ready", stop, 0);
        sb.push_back('{data, pc});
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'hx;
        e = sb.pop_front();
        chk("instr", Instruction, e.instr);
        chk("instr_pc", InstrPC, e.pc);
        chk("instr_valid", InstrValid, 1);
    endtask
    task automatic fetch(input vec_t v);
        logic [31:0] s0;
        PCValue = v.pc;
        #1;
        s0 = stall_cycles;
        chk("idle_stop", stop, 1);
        step();
        chk("req", mem_req, 1);
        chk("addr", 32'(mem_addr), 32'(v.addr));
        for (int i = 0; i < v.lat; i++) begin
            chk("wait_stop", stop, 1);
            chk("wait_req", mem_req, 1);
            chk("wait_addr", 32'(mem_addr), 32'(v.addr));
            step();
        end
        complete(v.data, v.pc);
`ifdef IFU_STALL_COUNT_EN
        chk("stall_cnt", stall_cycles, s0 + 32'(v.lat) + 32'd1);
`else
        chk("stall_zero", stall_cycles, 0);
`endif
    endtask
    initial begin
        vecs[0] = '{32'h0040_0000, 1, 32'h2008_0005, 10'd0};
        vecs[1] = '{32'h0040_0010, 4, 32'h8C09_0004, 10'd4};
        vecs[2] = '{32'h0040_0004, 0, 32'h0109_5020, 10'd1};
        vecs[3] = '{32'h0040_0FFC, 2, 32'hAC0A_0008, 10'd1023};
        vecs[4] = '{32'h0040_0800, 0, 32'h1234_5678, 10'd512};
        reset = 1'b1;
        flush = 1'b0;
        id_stall = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        PCValue = BASE;
        step();
        chk("rst_req", mem_req, 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_instr", Instruction, 0);
        chk("rst_pc", InstrPC, BASE);
        chk("rst_valid", InstrValid, 0);
        chk("rst_fault", addr_fault, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_stop", stop, 1);
        step();
        reset = 1'b0;
        foreach (vecs[i]) fetch(vecs[i]);
        // decode back-pressure holds the word and blocks new requests
        id_stall = 1'b1;
        PCValue = 32'h0040_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_req", mem_req, 0);
            chk("hold_valid", InstrValid, 1);
            chk("hold_instr", Instruction, vecs[4].data);
        end
        id_stall = 1'b0;
        step();
        chk("drain_valid", InstrValid, 0);
        chk("drain_req", mem_req, 1);
        chk("drain_addr", 32'(mem_addr), 64);
        complete(32'h1111_2222, 32'h0040_0100);
        // flush in the second REQ cycle, data returns two cycles later
        PCValue = 32'h0040_0020;
        step();
        chk("fl_req", mem_req, 1);
        chk("fl_addr", 32'(mem_addr), 8);
        step();
        flush = 1'b1;
        #1;
        chk("fl_stop", stop, 0);
        step();
        flush = 1'b0;
        PCValue = 32'h0040_0040;
        #1;
        chk("kill_stop", stop, 1);
        chk("kill_req", mem_req, 1);
        chk("kill_valid", InstrValid, 0);
        chk("kill_instr", Instruction, 0);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("kill_ready_stop", stop, 1);
        step();
        mem_ready = 1'b0;
        chk("kill_done_req", mem_req, 0);
        chk("kill_drop_valid", InstrValid, 0);
        chk("kill_drop_instr", Instruction, 0);
        step();
        chk("refetch_req", mem_req, 1);
        chk("refetch_addr", 32'(mem_addr), 16);
        complete(32'h2222_3333, 32'h0040_0040);
        // misaligned PC: sticky fault until reset
        PCValue = 32'h0040_0002;
        step();
        chk("mis_fault", addr_fault, 1);
        chk("mis_req", mem_req, 0);
        PCValue = BASE;
        #1;
        chk("mis_stop", stop, 1);
        step();
        chk("sticky_fault", addr_fault, 1);
        chk("sticky_req", mem_req, 0);
        reset = 1'b1;
        #1;
        chk("fault_clr", addr_fault, 0);
        step();
        reset = 1'b0;
        PCValue = 32'h0040_1000;
        step();
        chk("oor_fault", addr_fault, 1);
        chk("oor_req", mem_req, 0);
        chk("oor_stop", stop, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        PCValue = 32'h003F_FFFC;
        step();
        chk("low_fault", addr_fault, 1);
        chk("low_req", mem_req, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        // reset mid-fetch, then a late ready pulse
        PCValue = 32'h0040_0008;
        step();
        complete(32'h3333_4444, 32'h0040_0008);
        PCValue = 32'h0040_000C;
        step();
        chk("mid_req", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_instr", Instruction, 0);
        chk("mid_rst_pc", InstrPC, BASE);
        chk("mid_rst_valid", InstrValid, 0);
        chk("mid_rst_stop", stop, 1);
        chk("mid_rst_stall", stall_cycles, 0);
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        PCValue = 32'h0040_0010;
        step();
        mem_ready = 1'b0;
        chk("late_valid", InstrValid, 0);
        chk("late_instr", Instruction, 0);
        chk("late_req", mem_req, 1);
        complete(32'h4444_5555, 32'h0040_0010);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
